// File: rtl/disp_axi_pkg.sv
// Shared types and fixed AXI read attributes for the display read path.
package disp_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Fixed burst attributes driven on the M_AXI_AR* side by the top level.
    localparam logic [2:0] AXI_ARSIZE  = 3'b011;   // 8-byte beats
    localparam logic [1:0] AXI_ARBURST = 2'b01;    // INCR
    localparam logic [3:0] AXI_ARCACHE = 4'b0011;

endpackage

// File: rtl/disp_rr_pick.sv
// Two-way request picker: strict port-0 priority, or alternate on contention.
module disp_rr_pick #(
    parameter int C_PRIO0 = 1
) (
    input  logic [1:0] req_i,
    input  logic       last_i,   // 1: port 1 owned the previous burst
    output logic [1:0] win_o
);

    always_comb begin
        win_o = req_i;
        if (&req_i) win_o = ((C_PRIO0 != 0) || last_i) ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/disp_axi_rdarb.sv
// Two-requester arbiter for the display AXI read channel: one burst in flight,
// R beats routed to the owner only, sticky flag on RLAST/length disagreement.
module disp_axi_rdarb
    import disp_axi_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 64,
    parameter int C_PRIO0      = 1
) (
    input  logic                    ACLK,
    input  logic                    ARST,
    input  logic [C_ADDR_WIDTH-1:0] S0_ARADDR,
    input  logic [7:0]              S0_ARLEN,
    input  logic                    S0_ARVALID,
    output logic                    S0_ARREADY,
    output logic                    S0_RVALID,
    output logic                    S0_RLAST,
    input  logic                    S0_RREADY,
    input  logic [C_ADDR_WIDTH-1:0] S1_ARADDR,
    input  logic [7:0]              S1_ARLEN,
    input  logic                    S1_ARVALID,
    output logic                    S1_ARREADY,
    output logic                    S1_RVALID,
    output logic                    S1_RLAST,
    input  logic                    S1_RREADY,
    output logic [C_DATA_WIDTH-1:0] S_RDATA,
    output logic [C_ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]              M_ARLEN,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [C_DATA_WIDTH-1:0] M_RDATA,
    input  logic                    M_RLAST,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    output logic [1:0]              GRANT,
    output logic                    LEN_ERR,
    input  logic                    LEN_ERR_CLR
);

    state_e                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic                    arvalid_q, arvalid_d;
    logic                    last_q, last_d;
    logic [8:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [1:0]              win;
    logic                    in_addr, in_data, sel_rready, beat, err_set;

    disp_rr_pick #(.C_PRIO0(C_PRIO0)) u_pick (
        .req_i  ({S1_ARVALID, S0_ARVALID}),
        .last_i (last_q),
        .win_o  (win)
    );

    assign in_addr    = (state_q == ST_ADDR);
    assign in_data    = (state_q == ST_DATA);
    assign sel_rready = (grant_q[0] & S0_RREADY) | (grant_q[1] & S1_RREADY);
    assign beat       = in_data & M_RVALID & sel_rready;

    assign S0_ARREADY = in_addr & grant_q[0] & arvalid_q & M_ARREADY;
    assign S1_ARREADY = in_addr & grant_q[1] & arvalid_q & M_ARREADY;
    assign S0_RVALID  = in_data & grant_q[0] & M_RVALID;
    assign S1_RVALID  = in_data & grant_q[1] & M_RVALID;
    assign S0_RLAST   = in_data & grant_q[0] & M_RLAST;
    assign S1_RLAST   = in_data & grant_q[1] & M_RLAST;
    assign S_RDATA    = M_RDATA;
    assign M_RREADY   = in_data & sel_rready;
    assign M_ARADDR   = addr_q;
    assign M_ARLEN    = len_q;
    assign M_ARVALID  = arvalid_q;
    assign GRANT      = grant_q;
    assign LEN_ERR    = err_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        len_d     = len_q;
        arvalid_d = arvalid_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_set   = 1'b0;
        case (state_q)
            ST_IDLE: if (|win) begin
                grant_d   = win;
                addr_d    = win[0] ? S0_ARADDR : S1_ARADDR;
                len_d     = win[0] ? S0_ARLEN : S1_ARLEN;
                arvalid_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ADDR;
            end
            ST_ADDR: if (M_ARREADY) begin
                arvalid_d = 1'b0;
                state_d   = ST_DATA;
            end
            ST_DATA: if (beat) begin
                cnt_d = cnt_q + 9'd1;
                if (M_RLAST) begin
                    err_set = (cnt_q != {1'b0, len_q});
                    last_d  = grant_q[1];
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end else if (cnt_q >= {1'b0, len_q}) begin
                    // Overrun: keep routing until the slave ends the burst.
                    err_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_d = err_set | (err_q & ~LEN_ERR_CLR);
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            addr_q    <= '0;
            len_q     <= '0;
            arvalid_q <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            arvalid_q <= arvalid_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_disp_axi_rdarb.sv
// Bench for disp_axi_rdarb: one priority instance and one round-robin instance,
// driven by a requester/slave model and checked against the arbitration rules.
module tb_disp_axi_rdarb;
    localparam int AW = 32;
    localparam int DW = 64;

    logic ACLK = 1'b0;
    logic ARST = 1'b1;
    logic               clr [2];
    logic [AW-1:0]      s_araddr [2][2];
    logic [7:0]         s_arlen [2][2];
    logic               s_arvalid [2][2];
    logic               s_rready [2][2];
    logic               m_arready [2];
    logic [DW-1:0]      m_rdata [2];
    logic               m_rlast [2];
    logic               m_rvalid [2];
    logic [1:0][1:0]    s_arready, s_rvalid, s_rlast, grant;
    logic [1:0][DW-1:0] s_rdata;
    logic [1:0][AW-1:0] m_araddr;
    logic [1:0][7:0]    m_arlen;
    logic [1:0]         m_arvalid, m_rready, len_err;

    int n_tests = 0;
    int n_fail = 0;
    int mlast [2];
    logic exp_err [2];

    // Results of the last address / data phase.
    int r_lat, r_gp, r_pulses, r_early, r_beats, r_cycles, r_errs, r_leak;
    logic [1:0] r_gnt;
    logic [AW-1:0] r_addr;
    logic [7:0] r_len;

    always #5 ACLK = ~ACLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        disp_axi_rdarb #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_PRIO0(g == 0 ? 1 : 0)) u_dut (
            .ACLK(ACLK), .ARST(ARST),
            .S0_ARADDR(s_araddr[g][0]), .S0_ARLEN(s_arlen[g][0]), .S0_ARVALID(s_arvalid[g][0]),
            .S0_ARREADY(s_arready[g][0]), .S0_RVALID(s_rvalid[g][0]), .S0_RLAST(s_rlast[g][0]),
            .S0_RREADY(s_rready[g][0]),
            .S1_ARADDR(s_araddr[g][1]), .S1_ARLEN(s_arlen[g][1]), .S1_ARVALID(s_arvalid[g][1]),
            .S1_ARREADY(s_arready[g][1]), .S1_RVALID(s_rvalid[g][1]), .S1_RLAST(s_rlast[g][1]),
            .S1_RREADY(s_rready[g][1]),
            .S_RDATA(s_rdata[g]), .M_ARADDR(m_araddr[g]), .M_ARLEN(m_arlen[g]),
            .M_ARVALID(m_arvalid[g]), .M_ARREADY(m_arready[g]), .M_RDATA(m_rdata[g]),
            .M_RLAST(m_rlast[g]), .M_RVALID(m_rvalid[g]), .M_RREADY(m_rready[g]),
            .GRANT(grant[g]), .LEN_ERR(len_err[g]), .LEN_ERR_CLR(clr[g])
        );
    end

    task automatic raise(input int d, input int p, input logic [AW-1:0] a, input logic [7:0] l);
        s_araddr[d][p] = a;
        s_arlen[d][p] = l;
        s_arvalid[d][p] = 1'b1;
    endtask

    task automatic idle_cycle(input int d);
        @(negedge ACLK);
        m_rvalid[d] = 1'b0;
        m_rlast[d] = 1'b0;
        #1;
    endtask

    // Wait for M_ARVALID, accept it after dly cycles; R noise is offered meanwhile.
    task automatic addr_phase(input int d, input int dly, input logic [1:0] keep);
        r_lat = 0; r_gp = -1; r_pulses = 0; r_early = 0; r_gnt = 2'b11;
        do begin
            @(negedge ACLK);
            m_rvalid[d] = 1'($urandom_range(0, 1));
            m_rlast[d] = 1'($urandom_range(0, 1));
            #1;
            r_lat++;
            if (m_rready[d] !== 1'b0) r_early++;
        end while (m_arvalid[d] !== 1'b1 && r_lat < 50);
        r_addr = m_araddr[d];
        r_len = m_arlen[d];
        for (int i = 0; i <= dly; i++) begin
            if (i > 0) begin
                @(negedge ACLK);
                m_rvalid[d] = 1'($urandom_range(0, 1));
            end
            m_arready[d] = (i == dly);
            #1;
            if (m_rready[d] !== 1'b0) r_early++;
            if (s_arready[d][0] === 1'b1) begin r_pulses++; r_gp = 0; end
            if (s_arready[d][1] === 1'b1) begin r_pulses++; r_gp = 1; end
            if (i == dly) r_gnt = grant[d];
        end
        @(negedge ACLK);
        m_arready[d] = 1'b0;
        m_rvalid[d] = 1'b0;
        m_rlast[d] = 1'b0;
        if (r_gp >= 0 && !keep[r_gp]) s_arvalid[d][r_gp] = 1'b0;
        #1;
        if (s_arready[d][0] !== 1'b0 || s_arready[d][1] !== 1'b0) r_pulses++;
    endtask

    // Slave returns nbeats beats (RLAST on the last); the idle port's RREADY is the inverse.
    // rmode: 0 always ready, 1 RREADY toggles, 2 random RVALID/RREADY. Ends in the RLAST cycle.
    task automatic data_phase(input int d, input int gp, input int nbeats, input int rmode);
        logic rr;
        logic done;
        r_beats = 0; r_cycles = 0; r_errs = 0; r_leak = 0; done = 1'b0;
        while (!done && r_cycles < 600) begin
            if (r_cycles > 0) @(negedge ACLK);
            rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((r_cycles % 2) == 0) : 1'($urandom_range(0, 1));
            s_rready[d][gp] = rr;
            s_rready[d][1-gp] = ~rr;
            m_rvalid[d] = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            m_rdata[d] = {$urandom, $urandom};
            m_rlast[d] = (r_beats == nbeats - 1);
            #1;
            if (m_rready[d] !== rr || s_rvalid[d][gp] !== m_rvalid[d] ||
                s_rlast[d][gp] !== m_rlast[d] || s_rdata[d] !== m_rdata[d]) r_errs++;
            if (s_rvalid[d][1-gp] !== 1'b0 || s_rlast[d][1-gp] !== 1'b0) r_leak++;
            if (m_rvalid[d] && rr) begin
                r_beats++;
                if (m_rlast[d]) done = 1'b1;
            end
            r_cycles++;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            clr[d] = 1'b0; m_arready[d] = 1'b1; m_rdata[d] = '0; m_rlast[d] = 1'b1; m_rvalid[d] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                s_araddr[d][p] = $urandom; s_arlen[d][p] = 8'd3;
                s_arvalid[d][p] = 1'b1; s_rready[d][p] = 1'b1;
            end
        end
        ARST = 1'b1;
        repeat (3) @(negedge ACLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (grant[d] !== 2'b00 || m_arvalid[d] !== 1'b0 || m_araddr[d] !== '0 ||
                m_arlen[d] !== '0 || len_err[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_regs[%0d]: got grant=%b arvalid=%b araddr=%h arlen=%h len_err=%b, want all 0",
                         d, grant[d], m_arvalid[d], m_araddr[d], m_arlen[d], len_err[d]);
            end
            n_tests++;
            if (s_arready[d] !== 2'b00 || s_rvalid[d] !== 2'b00 || m_rready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_comb[%0d]: got arready=%b rvalid=%b m_rready=%b, want 0",
                         d, s_arready[d], s_rvalid[d], m_rready[d]);
            end
        end
        @(negedge ACLK);
        for (int d = 0; d < 2; d++) begin
            m_arready[d] = 1'b0; m_rvalid[d] = 1'b0; m_rlast[d] = 1'b0;
            s_arvalid[d][0] = 1'b0; s_arvalid[d][1] = 1'b0;
            mlast[d] = 1; exp_err[d] = 1'b0;
        end
        ARST = 1'b0;
    endtask

    task automatic test_single();
        @(negedge ACLK);
        raise(0, 0, 32'h2000_0000, 8'h1F);
        addr_phase(0, 3, 2'b00);
        n_tests++;
        if (r_lat != 1 || r_pulses != 1 || r_gp != 0 || r_gnt !== 2'b01 || r_early != 0) begin
            n_fail++;
            $display("FAIL single_addr: got lat=%0d pulses=%0d port=%0d grant=%b early_rready=%0d, want 1/1/0/01/0",
                     r_lat, r_pulses, r_gp, r_gnt, r_early);
        end
        n_tests++;
        if (r_addr !== 32'h2000_0000 || r_len !== 8'h1F) begin
            n_fail++;
            $display("FAIL single_ar: got addr=%h len=%h, want 20000000/1f", r_addr, r_len);
        end
        data_phase(0, 0, 32, 0);
        n_tests++;
        if (r_beats != 32 || r_errs != 0 || r_leak != 0) begin
            n_fail++;
            $display("FAIL single_data: got beats=%0d route_errs=%0d leak=%0d, want 32/0/0", r_beats, r_errs, r_leak);
        end
        idle_cycle(0);
        n_tests++;
        if (grant[0] !== 2'b00 || len_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: got grant=%b len_err=%b, want 00/0", grant[0], len_err[0]);
        end
    endtask

    task automatic test_rr();
        int nb [2];
        @(negedge ACLK);
        for (int p = 0; p < 2; p++) begin
            nb[p] = $urandom_range(1, 4);
            raise(1, p, $urandom, 8'(nb[p] - 1));
        end
        for (int k = 0; k < 4; k++) begin
            addr_phase(1, $urandom_range(0, 2), 2'b11);
            n_tests++;
            if (r_gp != k % 2 || r_gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10) || r_pulses != 1 ||
                r_lat != ((k == 0) ? 1 : 2) || r_addr !== s_araddr[1][k % 2] || r_early != 0) begin
                n_fail++;
                $display("FAIL rr_burst%0d: got port=%0d grant=%b pulses=%0d lat=%0d addr=%h early=%0d, want port %0d lat %0d addr %h",
                         k, r_gp, r_gnt, r_pulses, r_lat, r_addr, r_early, k % 2, (k == 0) ? 1 : 2, s_araddr[1][k % 2]);
            end
            data_phase(1, k % 2, nb[k % 2], 0);
            n_tests++;
            if (r_beats != nb[k % 2] || r_errs != 0 || r_leak != 0) begin
                n_fail++;
                $display("FAIL rr_data%0d: got beats=%0d errs=%0d leak=%0d, want %0d/0/0", k, r_beats, r_errs, r_leak, nb[k % 2]);
            end
            mlast[1] = k % 2;
        end
        s_arvalid[1][0] = 1'b0;
        s_arvalid[1][1] = 1'b0;
        idle_cycle(1);
    endtask

    task automatic test_prio();
        @(negedge ACLK);
        raise(0, 1, $urandom, 8'd2);
        addr_phase(0, 1, 2'b10);
        raise(0, 0, $urandom, 8'd5);
        n_tests++;
        if (r_gp != 1 || r_gnt !== 2'b10 || r_lat != 1) begin
            n_fail++;
            $display("FAIL prio_first: got port=%0d grant=%b lat=%0d, want 1/10/1", r_gp, r_gnt, r_lat);
        end
        data_phase(0, 1, 3, 0);
        n_tests++;
        if (r_beats != 3 || r_errs != 0 || r_leak != 0) begin
            n_fail++;
            $display("FAIL prio_p1_data: got beats=%0d errs=%0d leak=%0d, want 3/0/0", r_beats, r_errs, r_leak);
        end
        addr_phase(0, 0, 2'b10);
        n_tests++;
        if (r_gp != 0 || r_gnt !== 2'b01 || r_lat != 2 || r_addr !== s_araddr[0][0] || r_len !== 8'd5) begin
            n_fail++;
            $display("FAIL prio_second: got port=%0d grant=%b lat=%0d addr=%h len=%h, want port 0 grant 01 lat 2 len 05",
                     r_gp, r_gnt, r_lat, r_addr, r_len);
        end
        data_phase(0, 0, 6, 0);
        s_arvalid[0][1] = 1'b0;
        idle_cycle(0);
    endtask

    task automatic test_backpressure();
        @(negedge ACLK);
        raise(0, 0, $urandom, 8'h1F);
        addr_phase(0, 0, 2'b00);
        data_phase(0, 0, 32, 1);
        n_tests++;
        if (r_beats != 32 || r_cycles != 63 || r_errs != 0 || r_leak != 0) begin
            n_fail++;
            $display("FAIL backpressure: got beats=%0d cycles=%0d errs=%0d s1_leak=%0d, want 32/63/0/0",
                     r_beats, r_cycles, r_errs, r_leak);
        end
        idle_cycle(0);
        n_tests++;
        if (len_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_len: got len_err=%b, want 0", len_err[0]);
        end
    endtask

    task automatic test_len_err();
        @(negedge ACLK);
        clr[0] = 1'b1;
        raise(0, 0, $urandom, 8'h1F);
        addr_phase(0, 1, 2'b00);
        data_phase(0, 0, 16, 0);
        @(negedge ACLK);
        clr[0] = 1'b0;
        m_rvalid[0] = 1'b0;
        #1;
        n_tests++;
        if (len_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL len_short_set: got len_err=%b, want 1 (set beats clear)", len_err[0]);
        end
        for (int k = 0; k < 2; k++) begin
            raise(0, k, $urandom, 8'd3);
            addr_phase(0, 0, 2'b00);
            data_phase(0, k, 4, 0);
            idle_cycle(0);
            n_tests++;
            if (len_err[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL len_sticky%0d: got len_err=%b, want 1", k, len_err[0]);
            end
        end
        @(negedge ACLK);
        clr[0] = 1'b1;
        @(negedge ACLK);
        clr[0] = 1'b0;
        #1;
        n_tests++;
        if (len_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL len_clear: got len_err=%b, want 0", len_err[0]);
        end
    endtask

    task automatic test_random();
        int k, win, nb;
        logic [7:0] el;
        logic [AW-1:0] ea;
        for (int d = 0; d < 2; d++) begin
            idle_cycle(d);
            k = 0;
            while (k < 16 && (k < 6 || s_arvalid[d][0] || s_arvalid[d][1])) begin
                if (k < 6) begin
                    for (int p = 0; p < 2; p++)
                        if (!s_arvalid[d][p] && $urandom_range(0, 1) == 1)
                            raise(d, p, $urandom, 8'($urandom_range(0, 7)));
                    if (!s_arvalid[d][0] && !s_arvalid[d][1])
                        raise(d, int'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 7)));
                end
                // Strict priority favours port 0; round-robin favours the port not served last.
                if (s_arvalid[d][0] && s_arvalid[d][1]) win = (d == 0 || mlast[d] == 1) ? 0 : 1;
                else win = s_arvalid[d][0] ? 0 : 1;
                ea = s_araddr[d][win];
                el = s_arlen[d][win];
                nb = int'(el) + 1;
                case ($urandom_range(0, 5))
                    0: nb = int'(el) + 2;
                    1: if (el > 0) nb = int'(el);
                    default: ;
                endcase
                addr_phase(d, $urandom_range(0, 2), 2'b00);
                n_tests++;
                if (r_gp != win || r_gnt !== ((win == 0) ? 2'b01 : 2'b10) || r_addr !== ea || r_len !== el ||
                    r_pulses != 1 || r_lat != 1 || r_early != 0) begin
                    n_fail++;
                    $display("FAIL rand_addr[%0d.%0d]: got port=%0d grant=%b addr=%h len=%h pulses=%0d lat=%0d early=%0d, want port %0d addr %h len %h",
                             d, k, r_gp, r_gnt, r_addr, r_len, r_pulses, r_lat, r_early, win, ea, el);
                end
                data_phase(d, win, nb, 2);
                if (nb != int'(el) + 1) exp_err[d] = 1'b1;
                mlast[d] = win;
                idle_cycle(d);
                n_tests++;
                if (r_beats != nb || r_errs != 0 || r_leak != 0 || len_err[d] !== exp_err[d] || grant[d] !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d.%0d]: got beats=%0d errs=%0d leak=%0d len_err=%b grant=%b, want %0d/0/0/%b/00",
                             d, k, r_beats, r_errs, r_leak, len_err[d], grant[d], nb, exp_err[d]);
                end
                k++;
            end
            @(negedge ACLK);
            clr[d] = 1'b1;
            @(negedge ACLK);
            clr[d] = 1'b0;
            exp_err[d] = 1'b0;
        end
    endtask

    task automatic test_arst_mid();
        @(negedge ACLK);
        raise(0, 0, $urandom, 8'h1F);
        addr_phase(0, 0, 2'b00);
        repeat (4) begin
            @(negedge ACLK);
            m_rvalid[0] = 1'b1; m_rlast[0] = 1'b0; s_rready[0][0] = 1'b1;
        end
        @(negedge ACLK);
        ARST = 1'b1;
        @(negedge ACLK);
        #1;
        n_tests++;
        if (grant[0] !== 2'b00 || m_rready[0] !== 1'b0 || m_arvalid[0] !== 1'b0 || s_rvalid[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL arst_mid: got grant=%b m_rready=%b m_arvalid=%b rvalid=%b, want 00/0/0/00",
                     grant[0], m_rready[0], m_arvalid[0], s_rvalid[0]);
        end
        ARST = 1'b0;
        m_rvalid[0] = 1'b0;
        mlast[0] = 1; mlast[1] = 1;
        raise(0, 0, 32'h1234_5600, 8'd3);
        addr_phase(0, 2, 2'b00);
        n_tests++;
        if (r_gp != 0 || r_lat != 1 || r_pulses != 1 || r_addr !== 32'h1234_5600 || r_len !== 8'd3) begin
            n_fail++;
            $display("FAIL arst_regrant: got port=%0d lat=%0d pulses=%0d addr=%h len=%h, want 0/1/1/12345600/03",
                     r_gp, r_lat, r_pulses, r_addr, r_len);
        end
        data_phase(0, 0, 4, 0);
        idle_cycle(0);
        n_tests++;
        if (r_beats != 4 || r_errs != 0 || len_err[0] !== 1'b0 || grant[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL arst_burst: got beats=%0d errs=%0d len_err=%b grant=%b, want 4/0/0/00",
                     r_beats, r_errs, len_err[0], grant[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_prio();
        test_backpressure();
        test_len_err();
        test_random();
        test_arst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
